// File: rtl/arm_top.sv
// Fetch stage: PC register, combinational instruction ROM, IF/ID pipeline register.
// Latency: one cycle from pc_q to the PC/Instruction outputs.
// Backpressure: freeze holds pc_q and IF/ID; flush loads a zero bubble into IF/ID and wins over freeze.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst            - asynchronous active-low reset
//   freeze         - hold pc_q and the IF/ID register
//   flush          - IF/ID loads zeros
//   Branch_Tacken  - next pc_q comes from Branch_Address instead of pc_q+4
//   Branch_Address - byte address of the branch target
//   PC             - registered pc_q+4 of the fetched instruction
//   Instruction    - registered instruction word fetched at pc_q
module arm_top #(
  parameter int IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        Branch_Tacken,
  input  logic [31:0] Branch_Address,
  output logic [31:0] PC,
  output logic [31:0] Instruction
);

  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0]   pc_q;
  logic [31:0]   pc_plus4;
  logic [31:0]   next_pc;
  logic [AW-1:0] rom_idx;
  logic [31:0]   rom_word;

  assign pc_plus4 = pc_q + 32'd4;
  assign next_pc  = Branch_Tacken ? Branch_Address : pc_plus4;

  // Only the word-index bits select a ROM entry, so fetch addresses alias
  // modulo IMEM_WORDS*4.
  assign rom_idx = pc_q[AW+1:2];

  always_comb begin
    rom_word = 32'h0000_0000;
    case (32'(rom_idx))
      32'd0:   rom_word = 32'hE3A0_0014;
      32'd1:   rom_word = 32'hE3A0_1A01;
      32'd2:   rom_word = 32'hE3A0_2101;
      32'd3:   rom_word = 32'hE3A0_3102;
      32'd4:   rom_word = 32'hE080_4001;
      32'd5:   rom_word = 32'hE044_5002;
      32'd6:   rom_word = 32'hE1A0_6103;
      32'd7:   rom_word = 32'hE3A0_7000;
      default: rom_word = 32'h0000_0000;
    endcase
  end

  // Flush only bubbles IF/ID; pc_q keeps advancing (or branching) unless frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= 32'h0000_0000;
    end else if (!freeze) begin
      pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC          <= 32'h0000_0000;
      Instruction <= 32'h0000_0000;
    end else if (flush) begin
      PC          <= 32'h0000_0000;
      Instruction <= 32'h0000_0000;
    end else if (!freeze) begin
      PC          <= pc_plus4;
      Instruction <= rom_word;
    end
  end

endmodule

// File: tb/tb_arm_top.sv
// Directed bench for the arm_top fetch stage.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: freeze/flush exercised by directed vectors.
module tb_arm_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        Branch_Tacken;
  logic [31:0] Branch_Address;
  logic [31:0] PC;
  logic [31:0] Instruction;

  int n_checks = 0;
  int n_errors = 0;

  arm_top #(.IMEM_WORDS(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .flush          (flush),
    .Branch_Tacken  (Branch_Tacken),
    .Branch_Address (Branch_Address),
    .PC             (PC),
    .Instruction    (Instruction)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_ins);
    check_eq({tag, ".pc"},  PC,          exp_pc);
    check_eq({tag, ".ins"}, Instruction, exp_ins);
  endtask

  // Advance one rising edge and land 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fz, input logic fl, input logic br, input logic [31:0] ba);
    freeze         = fz;
    flush          = fl;
    Branch_Tacken  = br;
    Branch_Address = ba;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    expect_out("reset_init", 32'h0, 32'h0);

    // Reset holds state even with edges and a branch request present.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    step();
    expect_out("reset_hold", 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;

    // Sequential fetch from address 0.
    step(); expect_out("seq1", 32'h4, 32'hE3A0_0014);
    step(); expect_out("seq2", 32'h8, 32'hE3A0_1A01);

    // Branch to 0x14 with pc_q=8.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0014);
    step(); expect_out("br_edge", 32'hC, 32'hE3A0_2101);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(); expect_out("br_tgt", 32'h18, 32'hE044_5002);
    step(); expect_out("seq_w6", 32'h1C, 32'hE1A0_6103);
    step(); expect_out("seq_w7", 32'h20, 32'hE3A0_7000);
    step(); expect_out("unused_w8", 32'h24, 32'h0);

    // Async reset between edges.
    #3;
    rst = 1'b0;
    #1;
    expect_out("async_rst", 32'h0, 32'h0);
    step(); expect_out("async_rst_hold", 32'h0, 32'h0);
    rst = 1'b1;
    step(); expect_out("restart1", 32'h4, 32'hE3A0_0014);
    step(); expect_out("restart2", 32'h8, 32'hE3A0_1A01);

    // Freeze for three edges; a branch during freeze must be ignored.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step(); expect_out("frz1", 32'h8, 32'hE3A0_1A01);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    step(); expect_out("frz2_br", 32'h8, 32'hE3A0_1A01);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step(); expect_out("frz3", 32'h8, 32'hE3A0_1A01);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(); expect_out("frz_rel", 32'hC, 32'hE3A0_2101);

    // Flush bubbles IF/ID, pc_q keeps going (C -> 10).
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step(); expect_out("flush", 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(); expect_out("flush_resume", 32'h14, 32'hE080_4001);

    // Flush wins over freeze; pc_q (0x14) stays frozen.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step(); expect_out("flush_frz", 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(); expect_out("flush_frz_rel", 32'h18, 32'hE044_5002);

    // Branch with flush in the same edge, target 0x100 aliases to word 0.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    step(); expect_out("br_flush", 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(); expect_out("rom_wrap", 32'h104, 32'hE3A0_0014);

    // 32-bit PC wrap-around from FFFFFFFC.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(); expect_out("br_top", 32'h108, 32'hE3A0_1A01);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(); expect_out("pc_top", 32'h0, 32'h0);
    step(); expect_out("pc_wrap", 32'h4, 32'hE3A0_0014);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arm_top.md
ARM_TOP -- requirements
Module: arm_top

Interface
REQ-001 Parameter IMEM_WORDS, default 64, sets the instruction ROM depth in 32-bit words (power of two).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 freeze  input  1  high: hold PC register and IF/ID register.
REQ-005 flush  input  1  high: IF/ID register loads zeros (bubble).
REQ-006 Branch_Tacken  input  1  high: next PC comes from Branch_Address instead of PC+4.
REQ-007 Branch_Address  input  32  byte address of the branch target.
REQ-008 PC  output  32  registered IF/ID copy of the fetched instruction's PC+4.
REQ-009 Instruction  output  32  registered IF/ID copy of the fetched instruction word.

Function
REQ-010 The block SHALL implement the fetch stage as three elements: a PC register, a combinational instruction ROM and an IF/ID pipeline register.
REQ-011 The PC register (pc_q) SHALL be 32 bits and reset to 32'h0000_0000.
REQ-012 next_pc SHALL be Branch_Address when Branch_Tacken=1, otherwise pc_q+4 with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
REQ-013 On each rising clk edge pc_q SHALL load next_pc when freeze=0 and hold when freeze=1; a branch asserted during freeze is ignored.
REQ-014 The ROM SHALL be indexed by pc_q[log2(IMEM_WORDS)+1:2]; the upper address bits are ignored, so addresses wrap modulo IMEM_WORDS*4.
REQ-015 The ROM SHALL be read-only and combinational (zero latency). Words 0-7 are E3A00014, E3A01A01, E3A02101, E3A03102, E0804001, E0445002, E1A06103, E3A07000. All other words are 00000000.
REQ-016 The IF/ID register SHALL reset PC and Instruction to 0.
REQ-017 On each rising edge with flush=1, IF/ID SHALL load PC=0 and Instruction=0, regardless of freeze.
REQ-018 Otherwise, with freeze=0, IF/ID SHALL load PC=pc_q+4 and Instruction=ROM[pc_q].
REQ-019 Otherwise, with freeze=1, IF/ID SHALL hold its values.
REQ-020 flush SHALL NOT affect pc_q; freeze and Branch_Tacken SHALL NOT affect the PC+4 value latched into IF/ID.
REQ-021 Fetch-to-output latency SHALL be one cycle: the instruction at pc_q appears on Instruction after the next rising edge.
REQ-022 Branch_Tacken with flush in the same cycle: pc_q takes Branch_Address and IF/ID takes zeros.
REQ-023 Inputs SHALL be sampled only at rising edges; no combinational path SHALL exist from any input to PC or Instruction.

Reset
REQ-024 rst=0 SHALL force pc_q, PC and Instruction to 0 immediately, without waiting for a clock edge.
REQ-025 While rst=0, all state SHALL hold at 0 regardless of the other inputs.
REQ-026 After rst returns high, the first rising edge SHALL fetch address 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight state; fetch restarts at address 0.

Verification
REQ-028 Reset then sequential fetch: rst low, then high; freeze=flush=Branch_Tacken=0. After edges 1, 2, 3: (PC, Instruction) = (4, E3A00014), (8, E3A01A01), (C, E3A02101).
REQ-029 Branch: with pc_q=8, pulse Branch_Tacken=1 and Branch_Address=0x14 for one edge. That edge outputs (C, E3A02101); the next edge outputs (18, E0445002).
REQ-030 Freeze: assert freeze for 3 edges after PC=8. PC=8 and Instruction=E3A01A01 hold; after release the next edge outputs (C, E3A02101).
REQ-031 Flush: assert flush for one edge. Outputs become (0, 0). The following edge resumes with the next sequential address, since pc_q is unaffected.
REQ-032 Async reset mid-run: drive rst low between clock edges. PC and Instruction read 0 before the next edge; after release the sequence restarts at (4, E3A00014).
REQ-033 Wrap and unused ROM: branch to 0x100 with IMEM_WORDS=64; the next output is (104, E3A00014). Fetching word 8 returns 00000000.
